// File: rtl/sfu_in_packer.sv
// Serial-to-parallel packer that collects FP16 elements into N-lane vectors for the SFU.
// The pad value for unused lanes is 16'hFC00 when SFU_PACK_PAD_NEG_INF_EN is defined, otherwise 16'h0000.
module sfu_in_packer #(
  parameter int unsigned N      = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic                  s_tlast,
  output logic [N-1:0]          tvalid_out,
  output logic [N-1:0]          tlast_out,
  output logic [N*DATA_W-1:0]   tdata_out,
  input  logic                  out_ready
);

  localparam int unsigned LCW = (N > 1) ? $clog2(N) : 1;

`ifdef SFU_PACK_PAD_NEG_INF_EN
  localparam logic [DATA_W-1:0] PAD = DATA_W'(16'hFC00);
`else
  localparam logic [DATA_W-1:0] PAD = '0;
`endif

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [LCW-1:0]        lane_cnt_q, lane_cnt_d;
  logic                  hold_last_q, hold_last_d;
  logic [N*DATA_W-1:0]   asm_q, asm_d;
  logic [N-1:0]          out_valid_q, out_valid_d;
  logic [N-1:0]          out_last_q, out_last_d;
  logic [N*DATA_W-1:0]   out_data_q, out_data_d;

  logic accept;
  logic closing;
  logic out_busy;
  logic out_free;
  logic close_last;
  logic load;

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    hold_last_d = hold_last_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    out_busy   = |out_valid_q;
    out_free   = !out_busy || out_ready;
    accept     = s_tvalid && (state_q == FILL);
    closing    = accept && ((lane_cnt_q == LCW'(N - 1)) || s_tlast);
    close_last = (state_q == FILL) ? s_tlast : hold_last_q;
    load       = (closing || (state_q == HOLD)) && out_free;

    if (accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (LCW'(i) == lane_cnt_q) begin
          asm_d[i*DATA_W +: DATA_W] = s_tdata;
        end
      end
    end

    if (out_busy && out_ready) begin
      out_valid_d = '0;
      out_last_d  = '0;
    end

    // lane_cnt_q still holds the index of the closing lane, both on the
    // closing beat itself and throughout HOLD, so it defines the vector length.
    if (load) begin
      for (int unsigned i = 0; i < N; i++) begin
        out_valid_d[i] = (LCW'(i) <= lane_cnt_q);
        out_last_d[i]  = close_last && (LCW'(i) == lane_cnt_q);
        out_data_d[i*DATA_W +: DATA_W] =
          (LCW'(i) <= lane_cnt_q) ? asm_d[i*DATA_W +: DATA_W] : PAD;
      end
      lane_cnt_d = '0;
      state_d    = FILL;
    end else if (closing) begin
      state_d     = HOLD;
      hold_last_d = s_tlast;
    end else if (accept) begin
      lane_cnt_d = lane_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      lane_cnt_q  <= '0;
      hold_last_q <= 1'b0;
      asm_q       <= '0;
      out_valid_q <= '0;
      out_last_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      hold_last_q <= hold_last_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign s_tready   = (state_q == FILL);
  assign tvalid_out = out_valid_q;
  assign tlast_out  = out_last_q;
  assign tdata_out  = out_data_q;

endmodule

// File: tb/tb_sfu_in_packer.sv
// Directed bench for sfu_in_packer with immediate-assertion checks.
// Define SFU_PACK_PAD_NEG_INF_EN for both files to exercise -inf padding.
module tb_sfu_in_packer;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 16;

`ifdef SFU_PACK_PAD_NEG_INF_EN
  localparam logic [15:0] PAD = 16'hFC00;
`else
  localparam logic [15:0] PAD = 16'h0000;
`endif

  logic            clk;
  logic            rst_n;
  logic            s_tvalid;
  logic            s_tready;
  logic [DW-1:0]   s_tdata;
  logic            s_tlast;
  logic [N-1:0]    tvalid_out;
  logic [N-1:0]    tlast_out;
  logic [N*DW-1:0] tdata_out;
  logic            out_ready;

  int n_cmp;
  int n_err;

  sfu_in_packer #(.N(16), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .tvalid_out(tvalid_out),
    .tlast_out (tlast_out),
    .tdata_out (tdata_out),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one beat; returns #1 after the edge that sampled it.
  task automatic beat(input logic [15:0] d, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Lanes 0..k-1 = first, first+1, ...; remaining lanes = PAD.
  function automatic logic [255:0] seq_vec(input logic [15:0] first, input int unsigned k);
    logic [255:0] v;
    v = '0;
    for (int unsigned i = 0; i < N; i++)
      v[i*16 +: 16] = (i < k) ? first + 16'(i) : PAD;
    return v;
  endfunction

  logic [15:0]  vals [8];
  logic [255:0] exp_vec;
  logic [255:0] first_vec;
  logic         ready_dropped;

  initial begin
    n_cmp = 0;
    n_err = 0;
    vals[0] = 16'h3C00; vals[1] = 16'h4000; vals[2] = 16'h4200; vals[3] = 16'h4400;
    vals[4] = 16'h4500; vals[5] = 16'h4600; vals[6] = 16'h4700; vals[7] = 16'h4800;

    // Reset
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_tvalid", tvalid_out, 0);
    chk("rst_tlast", tlast_out, 0);
    chk("rst_tdata", tdata_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycle();
    chk("rst_tready", s_tready, 1);
    chk("rst_idle_tvalid", tvalid_out, 0);

    // Full 16-lane row ending in tlast on lane 15
    out_ready = 1'b1;
    for (int b = 0; b < 15; b++) beat(vals[b % 8], 1'b0);
    chk("t1_not_early", tvalid_out, 0);
    beat(vals[7], 1'b1);
    exp_vec = '0;
    for (int i = 0; i < 16; i++) exp_vec[i*16 +: 16] = vals[i % 8];
    chk("t1_tvalid", tvalid_out, 16'hFFFF);
    chk("t1_tlast", tlast_out, 16'h8000);
    chk("t1_tdata", tdata_out, exp_vec);
    idle_cycle();
    chk("t1_no_empty_vec", tvalid_out, 0);

    // Partial row of 5
    for (int b = 0; b < 4; b++) beat(16'h3C00, 1'b0);
    beat(16'h3C00, 1'b1);
    exp_vec = '0;
    for (int i = 0; i < 16; i++) exp_vec[i*16 +: 16] = (i < 5) ? 16'h3C00 : PAD;
    chk("t2_tvalid", tvalid_out, 16'h001F);
    chk("t2_tlast", tlast_out, 16'h0010);
    chk("t2_tdata", tdata_out, exp_vec);
    idle_cycle();
    chk("t2_clear", tvalid_out, 0);

    // Backpressure: 32 beats with out_ready low
    out_ready = 1'b0;
    for (int b = 1; b <= 16; b++) beat(16'h1000 + 16'(b), 1'b0);
    first_vec = seq_vec(16'h1001, 16);
    chk("t3_v1_tvalid", tvalid_out, 16'hFFFF);
    chk("t3_v1_tlast", tlast_out, 0);
    chk("t3_v1_tdata", tdata_out, first_vec);
    chk("t3_tready_mid", s_tready, 1);
    for (int b = 17; b <= 31; b++) beat(16'h1000 + 16'(b), 1'b0);
    chk("t3_tready_b31", s_tready, 1);
    beat(16'h1020, 1'b0);
    chk("t3_tready_hold", s_tready, 0);
    chk("t3_stable_tvalid", tvalid_out, 16'hFFFF);
    chk("t3_stable_tdata", tdata_out, first_vec);
    idle_cycle();
    chk("t3_still_held", tdata_out, first_vec);
    chk("t3_still_hold", s_tready, 0);
    out_ready = 1'b1;
    idle_cycle();
    chk("t3_v2_tvalid", tvalid_out, 16'hFFFF);
    chk("t3_v2_tdata", tdata_out, seq_vec(16'h1011, 16));
    chk("t3_v2_tlast", tlast_out, 0);
    chk("t3_tready_back", s_tready, 1);
    idle_cycle();
    chk("t3_drained", tvalid_out, 0);

    // 40 back-to-back beats, tlast on 40
    ready_dropped = 1'b0;
    for (int b = 1; b <= 40; b++) begin
      if (!s_tready) ready_dropped = 1'b1;
      beat(16'h2000 + 16'(b), b == 40);
      if (b == 16) begin
        chk("t4_v1_tvalid", tvalid_out, 16'hFFFF);
        chk("t4_v1_tdata", tdata_out, seq_vec(16'h2001, 16));
      end
      if (b == 17) chk("t4_v1_gone", tvalid_out, 0);
      if (b == 32) begin
        chk("t4_v2_tvalid", tvalid_out, 16'hFFFF);
        chk("t4_v2_tdata", tdata_out, seq_vec(16'h2011, 16));
      end
    end
    chk("t4_v3_tvalid", tvalid_out, 16'h00FF);
    chk("t4_v3_tlast", tlast_out, 16'h0080);
    chk("t4_v3_tdata", tdata_out, seq_vec(16'h2021, 8));
    chk("t4_tready_never_dropped", ready_dropped, 0);
    idle_cycle();

    // Reset mid-operation with a vector presented and a partial assembly
    out_ready = 1'b0;
    for (int b = 1; b <= 16; b++) beat(16'h5000 + 16'(b), 1'b0);
    for (int b = 17; b <= 23; b++) beat(16'h5000 + 16'(b), 1'b0);
    chk("t5_pre_rst_tvalid", tvalid_out, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tvalid", tvalid_out, 0);
    chk("t5_rst_tdata", tdata_out, 0);
    idle_cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle_cycle();
    idle_cycle();
    chk("t5_quiet_after_rst", tvalid_out, 0);
    for (int b = 1; b <= 16; b++) beat(16'h6000 + 16'(b), b == 16);
    chk("t5_tvalid", tvalid_out, 16'hFFFF);
    chk("t5_tlast", tlast_out, 16'h8000);
    chk("t5_lane0", tdata_out[15:0], 16'h6001);
    chk("t5_tdata", tdata_out, seq_vec(16'h6001, 16));
    idle_cycle();

    // Single-beat row
    beat(16'h3C00, 1'b1);
    chk("t6_tvalid", tvalid_out, 16'h0001);
    chk("t6_tlast", tlast_out, 16'h0001);
    chk("t6_tdata", tdata_out, seq_vec(16'h3C00, 1));
    idle_cycle();
    chk("t6_clear", tvalid_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sfu_in_packer.md
SFU_IN_PACKER -- requirements
Module: sfu_in_packer

Interface
REQ-001 SHALL have parameter N, default 16: number of FP16 lanes per packed vector.
REQ-002 SHALL have parameter DATA_W, default 16: lane width in bits, FP16.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port s_tvalid, input, 1 bit: serial input element valid.
REQ-006 SHALL have port s_tready, output, 1 bit: packer can accept an element.
REQ-007 SHALL have port s_tdata, input, DATA_W bits: FP16 element.
REQ-008 SHALL have port s_tlast, input, 1 bit: element is the last of the softmax row.
REQ-009 SHALL have port tvalid_out, output, N bits: per-lane valid, driven to the SFU tvalid_in.
REQ-010 SHALL have port tlast_out, output, N bits: per-lane last, driven to the SFU tlast_in.
REQ-011 SHALL have port tdata_out, output, N*DATA_W bits: packed vector, lane i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port out_ready, input, 1 bit: SFU can accept the presented vector.

Function
REQ-013 SHALL accept an input element on any clk edge where s_tvalid && s_tready.
REQ-014 SHALL write each accepted element into the assembly lane given by lane_cnt (0..N-1), then increment lane_cnt.
REQ-015 SHALL treat an accepted beat as closing when lane_cnt==N-1 or s_tlast==1.
REQ-016 SHALL, on a closing beat with the output register free, load the output register at that same edge:
- free means empty, or out_ready==1 while the register is presented.
- lane_cnt resets to 0.
- no bubble is inserted between vectors.
REQ-017 SHALL, on a closing beat with the output register occupied and not draining, enter state HOLD and deassert s_tready.
REQ-018 SHALL, in HOLD, move the assembly into the output register on the first edge where the output register is free, then return to FILL with s_tready=1.
REQ-019 SHALL implement two states, FILL and HOLD:
- FILL→HOLD per REQ-017.
- HOLD→FILL per REQ-018.
- s_tready = (state==FILL).
REQ-020 SHALL drive tvalid_out[i]=1 only for filled lanes 0..k-1 of a presented vector; tvalid_out SHALL be all zero when no vector is presented.
REQ-021 SHALL set tlast_out only on the highest valid lane, and only when the vector was closed by s_tlast; all other tlast_out bits SHALL be 0.
REQ-022 SHALL fill lanes k..N-1 of a partial vector with the pad value of REQ-031/REQ-032.
REQ-023 SHALL complete an output transfer on an edge where |tvalid_out && out_ready; with no new vector loaded at that edge, tvalid_out SHALL clear.
REQ-024 SHALL hold tvalid_out, tlast_out and tdata_out stable while presented and out_ready==0.
REQ-025 SHALL have latency of one edge from closing-beat acceptance to the vector appearing on tvalid_out (output register free).
REQ-026 SHALL, when s_tlast arrives on lane N-1, close the vector once with tlast_out[N-1]=1; no empty vector SHALL follow.
REQ-027 SHALL pass s_tdata bit-exact; the block SHALL perform no arithmetic on data.

Reset
REQ-028 SHALL, while rst_n==0, asynchronously force:
- state=FILL, lane_cnt=0, s_tready=1 after release.
- tvalid_out=0, tlast_out=0, tdata_out=0.
REQ-029 SHALL discard a partially filled assembly or a presented vector on reset mid-operation, with no output afterwards until new input.

Configuration
REQ-030 SHALL use macro SFU_PACK_PAD_NEG_INF_EN to select the pad value.
REQ-031 SHALL, with SFU_PACK_PAD_NEG_INF_EN defined, pad unused lanes with 16'hFC00 (FP16 -inf).
REQ-032 SHALL, without SFU_PACK_PAD_NEG_INF_EN, pad unused lanes with 16'h0000.

Verification
REQ-033 SHALL cover: 16 beats 0x3C00,0x4000,…,0x4800 (x2), s_tlast on beat 16, out_ready=1 -> one vector, tvalid_out=16'hFFFF, tlast_out=16'h8000, lanes match in order, one edge after beat 16.
REQ-034 SHALL cover: 5 beats 0x3C00 with s_tlast on beat 5 -> tvalid_out=16'h001F, tlast_out=16'h0010, lanes 5..15 = 0x0000 (0xFC00 with macro).
REQ-035 SHALL cover: out_ready=0, 32 continuous beats, no tlast -> first vector held stable, s_tready falls after beat 32; out_ready=1 -> two vectors delivered in order, s_tready=1 again.
REQ-036 SHALL cover: 40 back-to-back beats, s_tlast on beat 40, out_ready=1 -> vectors with masks FFFF, FFFF, 00FF; s_tready never drops.
REQ-037 SHALL cover: rst_n pulsed low after 7 beats -> outputs zero immediately; next 16 beats with tlast -> lane 0 holds the first post-reset beat.
REQ-038 SHALL cover: single beat with s_tlast -> tvalid_out=16'h0001, tlast_out=16'h0001.
